// File: rtl/freq_meter.sv
// freq_meter: measures the frequency of an asynchronous clock (clk_in) against
// clk_ref. It counts clk_in rising edges over a fixed gate window of
// GATE_CYCLES reference cycles. Each result (count plus a saturated N-bit
// control estimate) is offered to the consumer over a valid/ready handshake.
module freq_meter #(
    parameter int N           = 8,
    parameter int GATE_CYCLES = 256,
    parameter int CNT_W       = 16,
    parameter int SHIFT       = 0
) (
    input  logic             clk_ref,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clk_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_count,
    output logic [N-1:0]     ctrl_est,
    output logic             overrun
);

    localparam int               TW         = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_t;

    // Control estimate: count >> SHIFT, clamped to the largest N-bit code.
    // The comparison is done at CNT_W+N bits so it is correct for any N/CNT_W mix.
    function automatic logic [N-1:0] ctrl_from_count(input logic [CNT_W-1:0] count);
        logic [CNT_W+N-1:0] shifted;
        logic [CNT_W+N-1:0] limit;
        shifted = {{N{1'b0}}, (count >> SHIFT)};
        limit   = {{CNT_W{1'b0}}, {N{1'b1}}};
        if (shifted > limit) begin
            return {N{1'b1}};
        end else begin
            return shifted[N-1:0];
        end
    endfunction

    state_t           state_q;
    logic [TW-1:0]    timer_q;
    logic [TW-1:0]    timer_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             s1_q;
    logic             s2_q;
    logic             s3_q;
    logic             edge_s;
    logic             window_last_s;
    logic             load_s;
    logic             meas_valid_q;
    logic [CNT_W-1:0] meas_count_q;
    logic [N-1:0]     ctrl_est_q;
    logic             overrun_q;

    // Two-stage synchronizer for clk_in followed by a delay flop for edge detection.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= clk_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Edge detect, saturating count including this cycle's edge, and window-close load decision.
    always_comb begin
        edge_s        = s2_q & ~s3_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q + TW'(1);
        window_last_s = (state_q == ST_GATE) && (timer_q == TIMER_LAST);
        load_s        = 1'b0;
        if (edge_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (window_last_s) begin
            load_s = !meas_valid_q || meas_ready;
        end else begin
            load_s = 1'b0;
        end
    end

    // Gate FSM: window timing, edge counting, result capture, handshake and overrun flag.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= {TW{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            meas_valid_q <= 1'b0;
            meas_count_q <= {CNT_W{1'b0}};
            ctrl_est_q   <= {N{1'b0}};
            overrun_q    <= 1'b0;
        end else begin
            // A consume drops valid; a load in the same cycle below overrides it.
            if (meas_valid_q && meas_ready) begin
                meas_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    timer_q <= {TW{1'b0}};
                    cnt_q   <= {CNT_W{1'b0}};
                    if (enable) begin
                        state_q   <= ST_GATE;
                        overrun_q <= 1'b0;
                    end
                end
                ST_GATE: begin
                    if (window_last_s) begin
                        if (load_s) begin
                            meas_count_q <= cnt_d;
                            ctrl_est_q   <= ctrl_from_count(cnt_d);
                            meas_valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                        timer_q <= {TW{1'b0}};
                        cnt_q   <= {CNT_W{1'b0}};
                        if (!enable) begin
                            state_q <= ST_IDLE;
                        end
                    end else if (!enable) begin
                        // Abort: partial count is dropped, held result untouched.
                        state_q <= ST_IDLE;
                        timer_q <= {TW{1'b0}};
                        cnt_q   <= {CNT_W{1'b0}};
                    end else begin
                        timer_q <= timer_d;
                        cnt_q   <= cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= {TW{1'b0}};
                    cnt_q   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign meas_valid = meas_valid_q;
    assign meas_count = meas_count_q;
    assign ctrl_est   = ctrl_est_q;
    assign overrun    = overrun_q;

endmodule
